sram_port_arbiter: RTL

- Shares one single-port synchronous SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Owns the SRAM enable, write-enable, address and write-data pins.
- Returns read data or a write acknowledge to the granted stage.
- Raises a stall request to the pipeline controller while either stage is waiting.

---
 rtl/sram_port_arbiter_pkg.sv | 19 +
 rtl/sram_port_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM single-port SRAM arbiter.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    SRAM_ARB_IDLE  = 2'd0,
    SRAM_ARB_ISSUE = 2'd1,
    SRAM_ARB_WAIT  = 2'd2,
    SRAM_ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRAM_OWNER_IF  = 1'b0,
    SRAM_OWNER_MEM = 1'b1
  } arb_owner_e;

  localparam int SRAM_DEFAULT_LAT        = 1;
  localparam int SRAM_DEFAULT_STARVE_MAX = 4;

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between IF and MEM; fixed LAT+3 cycles per access,
// no pipelining. Waiting requesters are back-pressured through the combinational stallreq.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int LAT        = SRAM_DEFAULT_LAT,
  parameter int STARVE_MAX = SRAM_DEFAULT_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  input  logic        mem_req,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        stallreq,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [2:0] LAT_W    = 3'(LAT);
  localparam logic [3:0] STARVE_W = 4'(STARVE_MAX);

  arb_state_e  r_state;
  arb_state_e  w_next_state;
  arb_owner_e  r_owner;
  logic [31:0] r_addr;
  logic [3:0]  r_wen;
  logic [31:0] r_wdata;
  logic [2:0]  r_wait_cnt;
  logic [3:0]  r_starve_cnt;
  logic [31:0] r_rdata;
  logic [31:0] r_addr_hold;
  logic [31:0] r_wdata_hold;

  logic w_grant;
  logic w_grant_if;
  logic w_issue;
  logic w_resp;

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_if   = 1'b0;
    case (r_state)
      SRAM_ARB_IDLE: begin
        if (if_req || mem_req) begin
          w_grant      = 1'b1;
          // IF only beats a concurrent MEM request once MEM has starved it long enough
          w_grant_if   = if_req && (!mem_req || (r_starve_cnt == STARVE_W));
          w_next_state = SRAM_ARB_ISSUE;
        end
      end
      SRAM_ARB_ISSUE: w_next_state = SRAM_ARB_WAIT;
      SRAM_ARB_WAIT: begin
        if (r_wait_cnt == 3'd1) w_next_state = SRAM_ARB_RESP;
      end
      SRAM_ARB_RESP: w_next_state = SRAM_ARB_IDLE;
      default: w_next_state = SRAM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= SRAM_ARB_IDLE;
      r_owner      <= SRAM_OWNER_IF;
      r_addr       <= '0;
      r_wen        <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_rdata      <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_grant) begin
        r_owner <= w_grant_if ? SRAM_OWNER_IF : SRAM_OWNER_MEM;
        r_addr  <= w_grant_if ? if_addr : mem_addr;
        r_wen   <= w_grant_if ? 4'd0 : mem_wen;
        r_wdata <= w_grant_if ? r_wdata : mem_wdata;
        if (w_grant_if) begin
          r_starve_cnt <= '0;
        end else if (if_req && (r_starve_cnt != STARVE_W)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end

      if (r_state == SRAM_ARB_ISSUE) begin
        r_wait_cnt   <= LAT_W;
        r_addr_hold  <= r_addr;
        r_wdata_hold <= r_wdata;
      end else if (r_state == SRAM_ARB_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end

      // Stores leave the last load data untouched
      if ((r_state == SRAM_ARB_WAIT) && (r_wait_cnt == 3'd1) && (r_wen == 4'd0)) begin
        r_rdata <= sram_rdata;
      end
    end
  end

  assign w_issue = (r_state == SRAM_ARB_ISSUE);
  assign w_resp  = (r_state == SRAM_ARB_RESP);

  assign sram_en    = w_issue;
  assign sram_wen   = w_issue ? r_wen : 4'd0;
  assign sram_addr  = w_issue ? r_addr : r_addr_hold;
  assign sram_wdata = w_issue ? r_wdata : r_wdata_hold;

  assign if_rvalid  = w_resp && (r_owner == SRAM_OWNER_IF);
  assign mem_rvalid = w_resp && (r_owner == SRAM_OWNER_MEM);
  assign if_rdata   = if_rvalid ? r_rdata : 32'd0;
  assign mem_rdata  = mem_rvalid ? r_rdata : 32'd0;

  // Gated by rst so every output reads 0 while reset is held
  assign stallreq = rst && ((if_req && !if_rvalid) || (mem_req && !mem_rvalid));

endmodule
